// File: rtl/mem_pkg.sv
// Shared memory-subsystem types and widths for the block SRAM path.
// Holds the frame_writer descriptor bundle and FSM encoding.
package mem_pkg;

    localparam int BLOCK_BITS  = 64;
    localparam int ADDR_W      = 8;
    localparam int BLOCK_BYTES = BLOCK_BITS / 8;
    localparam int LEN_W       = 16;
    localparam int IDX_W       = (BLOCK_BYTES > 1) ? $clog2(BLOCK_BYTES) : 1;

    typedef struct packed {
        logic [ADDR_W-1:0] head;
        logic [LEN_W-1:0]  len;
        logic              err;
    } frame_desc_t;

    typedef enum logic [1:0] {
        S_ALLOC,
        S_FILL,
        S_DESC
    } fw_state_e;

endpackage

// File: rtl/frame_block_packer.sv
// Byte-to-block packer: collects bytes into one SRAM block and flags
// when the block closes (full or end of frame), zero-filling unused bytes.
module frame_block_packer
    import mem_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [7:0]            byte_data,
    input  logic                  last,
    output logic                  close,
    output logic [BLOCK_BITS-1:0] block
);

    logic [BLOCK_BITS-1:0] data_q, data_d;
    logic [IDX_W-1:0]      idx_q, idx_d;

    always_comb begin
        block = data_q;
        block[{idx_q, 3'b000} +: 8] = byte_data;
        close = push && (idx_q == IDX_W'(BLOCK_BYTES - 1) || last);
        data_d = data_q;
        idx_d  = idx_q;
        // Clearing on close keeps the tail of a short final block zero.
        if (close) begin
            data_d = '0;
            idx_d  = '0;
        end else if (push) begin
            data_d = block;
            idx_d  = idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            idx_q  <= '0;
        end else begin
            data_q <= data_d;
            idx_q  <= idx_d;
        end
    end

endmodule

// File: rtl/frame_writer.sv
// Ingress segmenter: packs a frame into free-list blocks, writes them to
// SRAM, links consecutive blocks and emits a frame descriptor.
module frame_writer
    import mem_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [7:0]            in_data,
    input  logic                  in_last,
    input  logic                  in_err,
    input  logic                  alloc_valid,
    input  logic [ADDR_W-1:0]     alloc_addr,
    output logic                  alloc_ready,
    output logic                  sram_we,
    output logic [ADDR_W-1:0]     sram_w_addr,
    output logic [BLOCK_BITS-1:0] sram_wdata,
    output logic                  link_we,
    output logic [ADDR_W-1:0]     link_addr,
    output logic [ADDR_W-1:0]     link_next,
    output logic                  desc_valid,
    input  logic                  desc_ready,
    output logic [ADDR_W-1:0]     desc_head,
    output logic [LEN_W-1:0]      desc_len,
    output logic                  desc_err
);

    fw_state_e             state_q, state_d;
    frame_desc_t           desc_q, desc_d;
    logic [ADDR_W-1:0]     cur_q, cur_d;
    logic [ADDR_W-1:0]     prev_q, prev_d;
    logic                  started_q, started_d;
    logic                  ovf_q, ovf_d;
    logic                  sram_we_q, sram_we_d;
    logic [ADDR_W-1:0]     sram_addr_q, sram_addr_d;
    logic [BLOCK_BITS-1:0] sram_wdata_q, sram_wdata_d;
    logic                  link_we_q, link_we_d;
    logic [ADDR_W-1:0]     link_addr_q, link_addr_d;
    logic [ADDR_W-1:0]     link_next_q, link_next_d;

    logic                  push;
    logic                  close;
    logic [BLOCK_BITS-1:0] block;

    assign in_ready    = (state_q == S_FILL);
    assign alloc_ready = (state_q == S_ALLOC);
    assign desc_valid  = (state_q == S_DESC);
    assign push        = in_valid && in_ready;

    assign sram_we     = sram_we_q;
    assign sram_w_addr = sram_addr_q;
    assign sram_wdata  = sram_wdata_q;
    assign link_we     = link_we_q;
    assign link_addr   = link_addr_q;
    assign link_next   = link_next_q;
    assign desc_head   = desc_q.head;
    assign desc_len    = desc_q.len;
    assign desc_err    = desc_q.err;

    frame_block_packer u_packer (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .byte_data (in_data),
        .last      (in_last),
        .close     (close),
        .block     (block)
    );

    always_comb begin
        state_d      = state_q;
        desc_d       = desc_q;
        cur_d        = cur_q;
        prev_d       = prev_q;
        started_d    = started_q;
        ovf_d        = ovf_q;
        sram_we_d    = 1'b0;
        sram_addr_d  = sram_addr_q;
        sram_wdata_d = sram_wdata_q;
        link_we_d    = 1'b0;
        link_addr_d  = link_addr_q;
        link_next_d  = link_next_q;
        unique case (state_q)
            S_ALLOC: begin
                if (alloc_valid) begin
                    cur_d     = alloc_addr;
                    started_d = 1'b1;
                    state_d   = S_FILL;
                    if (!started_q) begin
                        desc_d.head = alloc_addr;
                    end else begin
                        link_we_d   = 1'b1;
                        link_addr_d = prev_q;
                        link_next_d = alloc_addr;
                    end
                end
            end
            S_FILL: begin
                if (push) begin
                    if (&desc_q.len) begin
                        ovf_d = 1'b1;
                    end else begin
                        desc_d.len = desc_q.len + 1'b1;
                    end
                    if (close) begin
                        sram_we_d    = 1'b1;
                        sram_addr_d  = cur_q;
                        sram_wdata_d = block;
                        prev_d       = cur_q;
                        if (in_last) begin
                            desc_d.err = in_err | ovf_d;
                            state_d    = S_DESC;
                        end else begin
                            state_d = S_ALLOC;
                        end
                    end
                end
            end
            S_DESC: begin
                if (desc_ready) begin
                    desc_d.len = '0;
                    ovf_d      = 1'b0;
                    started_d  = 1'b0;
                    state_d    = S_ALLOC;
                end
            end
            default: state_d = S_ALLOC;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_ALLOC;
            desc_q       <= '0;
            cur_q        <= '0;
            prev_q       <= '0;
            started_q    <= 1'b0;
            ovf_q        <= 1'b0;
            sram_we_q    <= 1'b0;
            sram_addr_q  <= '0;
            sram_wdata_q <= '0;
            link_we_q    <= 1'b0;
            link_addr_q  <= '0;
            link_next_q  <= '0;
        end else begin
            state_q      <= state_d;
            desc_q       <= desc_d;
            cur_q        <= cur_d;
            prev_q       <= prev_d;
            started_q    <= started_d;
            ovf_q        <= ovf_d;
            sram_we_q    <= sram_we_d;
            sram_addr_q  <= sram_addr_d;
            sram_wdata_q <= sram_wdata_d;
            link_we_q    <= link_we_d;
            link_addr_q  <= link_addr_d;
            link_next_q  <= link_next_d;
        end
    end

endmodule

// File: tb/tb_frame_writer.sv
// Self-checking bench for frame_writer with a scoreboard of expected
// block writes, link writes and descriptors.
module tb_frame_writer;
    import mem_pkg::*;

    typedef struct {
        logic [ADDR_W-1:0]     addr;
        logic [BLOCK_BITS-1:0] data;
    } wr_t;

    typedef struct {
        logic [ADDR_W-1:0] from;
        logic [ADDR_W-1:0] to;
    } lk_t;

    logic                  clk;
    logic                  rst_n;
    logic                  in_valid;
    logic                  in_ready;
    logic [7:0]            in_data;
    logic                  in_last;
    logic                  in_err;
    logic                  alloc_valid;
    logic [ADDR_W-1:0]     alloc_addr;
    logic                  alloc_ready;
    logic                  sram_we;
    logic [ADDR_W-1:0]     sram_w_addr;
    logic [BLOCK_BITS-1:0] sram_wdata;
    logic                  link_we;
    logic [ADDR_W-1:0]     link_addr;
    logic [ADDR_W-1:0]     link_next;
    logic                  desc_valid;
    logic                  desc_ready;
    logic [ADDR_W-1:0]     desc_head;
    logic [LEN_W-1:0]      desc_len;
    logic                  desc_err;

    logic [ADDR_W-1:0] fl [8] = '{8'd5, 8'd9, 8'd2, 8'd7,
                                  8'd3, 8'd11, 8'd4, 8'd6};
    int                fl_ptr;
    logic              fl_en;
    int                mp;
    int                n_chk;
    int                n_err;

    wr_t         wr_q [$];
    lk_t         lk_q [$];
    frame_desc_t dq [$];
    logic [7:0]  fr [$];

    assign alloc_valid = fl_en;
    assign alloc_addr  = fl[fl_ptr % 8];

    frame_writer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_last     (in_last),
        .in_err      (in_err),
        .alloc_valid (alloc_valid),
        .alloc_addr  (alloc_addr),
        .alloc_ready (alloc_ready),
        .sram_we     (sram_we),
        .sram_w_addr (sram_w_addr),
        .sram_wdata  (sram_wdata),
        .link_we     (link_we),
        .link_addr   (link_addr),
        .link_next   (link_next),
        .desc_valid  (desc_valid),
        .desc_ready  (desc_ready),
        .desc_head   (desc_head),
        .desc_len    (desc_len),
        .desc_err    (desc_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) fl_ptr <= 0;
        else if (alloc_valid && alloc_ready) fl_ptr <= fl_ptr + 1;
    end

    task automatic chk(input string tag, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got %0h expected %0h", tag, act, exp);
        end
    endtask

    wr_t         mw;
    lk_t         ml;
    frame_desc_t md;

    always @(negedge clk) begin
        if (rst_n) begin
            if (sram_we) begin
                if (wr_q.size() == 0) chk("wr_unexpected", 1, 0);
                else begin
                    mw = wr_q.pop_front();
                    chk("wr_addr", 64'(sram_w_addr), 64'(mw.addr));
                    chk("wr_data", sram_wdata, mw.data);
                end
            end
            if (link_we) begin
                if (lk_q.size() == 0) chk("link_unexpected", 1, 0);
                else begin
                    ml = lk_q.pop_front();
                    chk("link_addr", 64'(link_addr), 64'(ml.from));
                    chk("link_next", 64'(link_next), 64'(ml.to));
                end
            end
            if (desc_valid && desc_ready) begin
                if (dq.size() == 0) chk("desc_unexpected", 1, 0);
                else begin
                    md = dq.pop_front();
                    chk("desc_head", 64'(desc_head), 64'(md.head));
                    chk("desc_len", 64'(desc_len), 64'(md.len));
                    chk("desc_err", 64'(desc_err), 64'(md.err));
                end
            end
        end
    end

    task automatic mk(input int n, input int base);
        fr = {};
        for (int i = 0; i < n; i++) fr.push_back(8'(base + i));
    endtask

    task automatic expect_frame(input logic err);
        int                    n;
        int                    nblk;
        logic [ADDR_W-1:0]     a;
        logic [ADDR_W-1:0]     prev;
        logic [BLOCK_BITS-1:0] d;
        frame_desc_t           fd;
        n    = fr.size();
        nblk = (n + BLOCK_BYTES - 1) / BLOCK_BYTES;
        prev = '0;
        fd   = '0;
        for (int k = 0; k < nblk; k++) begin
            a = fl[mp % 8];
            mp++;
            d = '0;
            for (int j = 0; j < BLOCK_BYTES; j++) begin
                if (k * BLOCK_BYTES + j < n)
                    d[j*8 +: 8] = fr[k * BLOCK_BYTES + j];
            end
            wr_q.push_back('{addr: a, data: d});
            if (k == 0) fd.head = a;
            else lk_q.push_back('{from: prev, to: a});
            prev = a;
        end
        fd.len = LEN_W'(n);
        fd.err = err;
        dq.push_back(fd);
    endtask

    task automatic send_bytes(input int lo, input int hi, input logic err);
        int t;
        for (int i = lo; i <= hi; i++) begin
            in_valid = 1'b1;
            in_data  = fr[i];
            in_last  = (i == fr.size() - 1);
            in_err   = in_last ? err : 1'b0;
            t = 0;
            while (!in_ready && t < 500) begin
                @(posedge clk); #1;
                t++;
            end
            if (t >= 500) chk("in_ready_timeout", 0, 1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_err   = 1'b0;
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (dq.size() != 0 && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        chk("desc_pending", 64'(dq.size()), 0);
    endtask

    task automatic check_reset_vals();
        chk("rst_in_ready", 64'(in_ready), 0);
        chk("rst_alloc_ready", 64'(alloc_ready), 1);
        chk("rst_desc_valid", 64'(desc_valid), 0);
        chk("rst_sram_we", 64'(sram_we), 0);
        chk("rst_sram_wdata", sram_wdata, 0);
        chk("rst_link_we", 64'(link_we), 0);
        chk("rst_desc_len", 64'(desc_len), 0);
        chk("rst_desc_head", 64'(desc_head), 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        mp    = 0;
        wr_q  = {};
        lk_q  = {};
        dq    = {};
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        n_chk      = 0;
        n_err      = 0;
        mp         = 0;
        rst_n      = 1'b1;
        in_valid   = 1'b0;
        in_data    = '0;
        in_last    = 1'b0;
        in_err     = 1'b0;
        fl_en      = 1'b1;
        desc_ready = 1'b1;
        #1 rst_n = 1'b0;
        #1 check_reset_vals();
        do_reset();

        mk(3, 8'hA1);
        expect_frame(1'b0);
        send_bytes(0, 2, 1'b0);
        wait_done();

        do_reset();
        mk(8, 8'h10);
        expect_frame(1'b0);
        send_bytes(0, 7, 1'b0);
        chk("full_desc_valid", 64'(desc_valid), 1);
        chk("full_one_pop", 64'(fl_ptr), 1);
        wait_done();

        do_reset();
        mk(20, 8'h40);
        expect_frame(1'b0);
        send_bytes(0, 19, 1'b0);
        wait_done();

        do_reset();
        mk(12, 8'h60);
        expect_frame(1'b0);
        send_bytes(0, 7, 1'b0);
        fl_en = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            chk("stall_in_ready", 64'(in_ready), 0);
            chk("stall_sram_we", 64'(sram_we), 0);
            chk("stall_link_we", 64'(link_we), 0);
        end
        fl_en = 1'b1;
        send_bytes(8, 11, 1'b0);
        wait_done();

        do_reset();
        desc_ready = 1'b0;
        mk(3, 8'h31);
        expect_frame(1'b0);
        send_bytes(0, 2, 1'b0);
        repeat (5) begin
            chk("hold_desc_valid", 64'(desc_valid), 1);
            chk("hold_desc_head", 64'(desc_head), 64'(fl[0]));
            chk("hold_desc_len", 64'(desc_len), 3);
            chk("hold_desc_err", 64'(desc_err), 0);
            chk("hold_in_ready", 64'(in_ready), 0);
            @(posedge clk); #1;
        end
        desc_ready = 1'b1;
        wait_done();
        mk(2, 8'hE0);
        expect_frame(1'b1);
        send_bytes(0, 1, 1'b1);
        wait_done();

        do_reset();
        mk(6, 8'h70);
        send_bytes(0, 2, 1'b0);
        in_valid = 1'b1;
        rst_n = 1'b0;
        #1 check_reset_vals();
        in_valid = 1'b0;
        do_reset();
        mk(5, 8'h80);
        expect_frame(1'b0);
        send_bytes(0, 4, 1'b0);
        wait_done();

        repeat (3) @(posedge clk);
        #1;
        chk("wr_q_left", 64'(wr_q.size()), 0);
        chk("lk_q_left", 64'(lk_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
